// File: rtl/multi_debouncer.sv
// Multi-channel push-button debouncer: 2-flop sync, stability counter, level and edge pulses.
// Define MULTI_DEBOUNCER_HOLD_EN to build the per-channel hold / auto-repeat pulse generator.
module multi_debouncer #(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned STABLE_CYCLES = 16,
  parameter bit          ACTIVE_LOW    = 1'b0,
  parameter int unsigned HOLD_CYCLES   = 1000,
  parameter int unsigned REPEAT_CYCLES = 250
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] btn_in,
  output logic [CHANNELS-1:0] btn_level,
  output logic [CHANNELS-1:0] btn_rise,
  output logic [CHANNELS-1:0] btn_fall,
  output logic [CHANNELS-1:0] btn_hold
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  if (CHANNELS < 1 || CHANNELS > 32 || STABLE_CYCLES < 2 ||
      HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_cfg
    $error("multi_debouncer: parameter out of range");
  end

  logic [CHANNELS-1:0] s1;
  logic [CHANNELS-1:0] s2;
  logic [CW-1:0]       cnt [CHANNELS];
  logic [CHANNELS-1:0] flip;

  // A channel toggles on the edge where it has disagreed for the full window.
  always_comb begin
    flip = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      flip[c] = (s2[c] != btn_level[c]) && (cnt[c] == CNT_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1        <= '0;
      s2        <= '0;
      btn_level <= '0;
      btn_rise  <= '0;
      btn_fall  <= '0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        cnt[c] <= '0;
      end
    end else begin
      s1        <= btn_in ^ {CHANNELS{ACTIVE_LOW}};
      s2        <= s1;
      btn_level <= btn_level ^ flip;
      btn_rise  <= flip & ~btn_level;
      btn_fall  <= flip & btn_level;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        if (s2[c] == btn_level[c] || flip[c]) begin
          cnt[c] <= '0;
        end else begin
          cnt[c] <= cnt[c] + 1'b1;
        end
      end
    end
  end

`ifdef MULTI_DEBOUNCER_HOLD_EN
  localparam int unsigned HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned HW   = $clog2(HMAX) + 1;
  localparam logic [HW-1:0] HOLD_T = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] REP_T  = HW'(REPEAT_CYCLES);

  logic [HW-1:0]       hc [CHANNELS];
  logic [CHANNELS-1:0] rep;

  // hc restarts from zero after every pulse; rep selects the first-hold or repeat interval.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_hold <= '0;
      rep      <= '0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        hc[c] <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        if (flip[c] || !btn_level[c]) begin
          hc[c]       <= '0;
          rep[c]      <= 1'b0;
          btn_hold[c] <= 1'b0;
        end else if (HW'(hc[c] + 1'b1) == (rep[c] ? REP_T : HOLD_T)) begin
          hc[c]       <= '0;
          rep[c]      <= 1'b1;
          btn_hold[c] <= 1'b1;
        end else begin
          hc[c]       <= hc[c] + 1'b1;
          btn_hold[c] <= 1'b0;
        end
      end
    end
  end
`else
  assign btn_hold = '0;
`endif

endmodule

// File: tb/tb_multi_debouncer.sv
// Self-checking bench for multi_debouncer: vector table, directed corner sequences and a
// randomized run against a sliding-window reference model.
module tb_multi_debouncer;

  localparam int unsigned CH   = 4;
  localparam int unsigned ST   = 16;
  localparam int unsigned HOLD = 100;
  localparam int unsigned REP  = 20;

  logic          clk = 1'b0;
  logic          reset;
  logic [CH-1:0] btn_in;
  logic [CH-1:0] btn_level;
  logic [CH-1:0] btn_rise;
  logic [CH-1:0] btn_fall;
  logic [CH-1:0] btn_hold;

  multi_debouncer #(
    .CHANNELS(CH),
    .STABLE_CYCLES(ST),
    .ACTIVE_LOW(1'b0),
    .HOLD_CYCLES(HOLD),
    .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_in(btn_in),
    .btn_level(btn_level),
    .btn_rise(btn_rise),
    .btn_fall(btn_fall),
    .btn_hold(btn_hold)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int rise_cnt [CH];
  int fall_cnt [CH];
  int hold_cnt [CH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a level flips once the last ST synchronised samples all differ from it.
  // hist[0] is the sample taken on the previous edge; the synchroniser adds one more edge.
  logic [ST:0][CH-1:0] hist;
  logic [CH-1:0]       m_level, m_rise, m_fall, m_hold, m_tog;
  int unsigned         m_since [CH];
  logic                model_on = 1'b0;

  function automatic logic [CH-1:0] calc_tog(input logic [ST:0][CH-1:0] h, input logic [CH-1:0] lvl);
    logic [CH-1:0] t;
    t = '1;
    for (int j = 1; j <= int'(ST); j++) t = t & (h[j] ^ lvl);
    return t;
  endfunction

  function automatic logic hold_due(input int unsigned k);
`ifdef MULTI_DEBOUNCER_HOLD_EN
    return (k >= HOLD) && (((k - HOLD) % REP) == 0);
`else
    return (k == 32'hFFFF_FFFF);
`endif
  endfunction

  always_comb m_tog = calc_tog(hist, m_level);

  always @(posedge clk) begin
    if (reset) begin
      hist     <= '0;
      m_level  <= '0;
      m_rise   <= '0;
      m_fall   <= '0;
      m_hold   <= '0;
      model_on <= 1'b1;
      for (int c = 0; c < int'(CH); c++) m_since[c] <= 0;
    end else begin
      hist    <= {hist[ST-1:0], btn_in};
      m_level <= m_level ^ m_tog;
      m_rise  <= m_tog & ~m_level;
      m_fall  <= m_tog & m_level;
      for (int c = 0; c < int'(CH); c++) begin
        if (m_tog[c] || !m_level[c]) begin
          m_since[c] <= 0;
          m_hold[c]  <= 1'b0;
        end else begin
          m_since[c] <= m_since[c] + 1;
          m_hold[c]  <= hold_due(m_since[c] + 1);
        end
      end
    end
  end

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (model_on) begin
        check("model_level", 32'(btn_level), 32'(m_level));
        check("model_rise",  32'(btn_rise),  32'(m_rise));
        check("model_fall",  32'(btn_fall),  32'(m_fall));
        check("model_hold",  32'(btn_hold),  32'(m_hold));
      end
      for (int c = 0; c < int'(CH); c++) begin
        if (btn_rise[c]) rise_cnt[c]++;
        if (btn_fall[c]) fall_cnt[c]++;
        if (btn_hold[c]) hold_cnt[c]++;
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [CH-1:0] drive;
    int            len;
    logic [CH-1:0] exp_level;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int r0, f0, h0, seen;
    for (int c = 0; c < int'(CH); c++) begin
      rise_cnt[c] = 0;
      fall_cnt[c] = 0;
      hold_cnt[c] = 0;
    end
    vecs[0] = '{4'b0000, 17, 4'b1111};
    vecs[1] = '{4'b0000,  1, 4'b0000};
    vecs[2] = '{4'b1111, 10, 4'b0000};
    vecs[3] = '{4'b0000,  5, 4'b0000};
    vecs[4] = '{4'b1111, 18, 4'b1111};
    vecs[5] = '{4'b0101, 18, 4'b0101};
    vecs[6] = '{4'b1010, 18, 4'b1010};
    vecs[7] = '{4'b1010, 50, 4'b1010};
    vecs[8] = '{4'b0000, 18, 4'b0000};

    reset  = 1'b1;
    btn_in = '1;
    fork monitor(); join_none

    // Reset with inputs held high, then the 18-edge first press.
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("reset_outputs", 32'({btn_level, btn_rise, btn_fall, btn_hold}), 32'h0);
    end
    reset = 1'b0;
    tick(17);
    check("latency_level_early", 32'(btn_level), 32'h0);
    tick(1);
    check("latency_level", 32'(btn_level), 32'hF);
    check("latency_rise", 32'(btn_rise), 32'hF);
    tick(1);
    check("rise_single_cycle", 32'(btn_rise), 32'h0);

    for (int i = 0; i < 9; i++) begin
      btn_in = vecs[i].drive;
      tick(vecs[i].len);
      check("table_level", 32'(btn_level), 32'(vecs[i].exp_level));
    end

    // Ch0 bounce every 5 cycles, then a clean hold.
    r0 = rise_cnt[0];
    for (int seg = 0; seg < 20; seg++) begin
      btn_in[0] = ((seg % 2) == 0);
      tick(5);
    end
    check("bounce_no_rise", 32'(rise_cnt[0] - r0), 32'h0);
    btn_in[0] = 1'b1;
    tick(17);
    check("bounce_level_early", 32'(btn_level), 32'h0);
    tick(1);
    check("bounce_level", 32'(btn_level), 32'h1);
    check("bounce_rise", 32'(btn_rise), 32'h1);

    // Ch1 glitch of 15 cycles is swallowed; 16 cycles gets through.
    r0 = rise_cnt[1];
    f0 = fall_cnt[1];
    btn_in = 4'b0011;
    tick(15);
    btn_in = 4'b0001;
    tick(30);
    check("glitch15_level", 32'(btn_level), 32'h1);
    check("glitch15_pulses", 32'((rise_cnt[1] - r0) + (fall_cnt[1] - f0)), 32'h0);
    btn_in = 4'b0011;
    tick(16);
    btn_in = 4'b0001;
    tick(17);
    check("glitch16_level_high", 32'(btn_level), 32'h3);
    check("glitch16_rise_once", 32'(rise_cnt[1] - r0), 32'h1);
    tick(1);
    check("glitch16_fall_level", 32'(btn_level), 32'h1);
    check("glitch16_fall", 32'(btn_fall), 32'h2);

    // Ch2 rises while ch3 falls on the same cycle.
    btn_in = 4'b1001;
    tick(20);
    check("simul_setup", 32'(btn_level), 32'h9);
    btn_in = 4'b0101;
    tick(18);
    check("simul_rise", 32'(btn_rise), 32'h4);
    check("simul_fall", 32'(btn_fall), 32'h8);

    // Reset part-way through a count restarts the full latency.
    btn_in = 4'b0000;
    tick(20);
    check("midreset_setup", 32'(btn_level), 32'h0);
    btn_in = 4'b0001;
    tick(10);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    r0 = rise_cnt[0];
    tick(17);
    check("midreset_level_early", 32'(btn_level), 32'h0);
    check("midreset_no_rise", 32'(rise_cnt[0] - r0), 32'h0);
    tick(1);
    check("midreset_level", 32'(btn_level), 32'h1);
    check("midreset_rise", 32'(btn_rise), 32'h1);

`ifdef MULTI_DEBOUNCER_HOLD_EN
    btn_in = 4'b0000;
    tick(20);
    btn_in = 4'b0001;
    seen = 0;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      tick(1);
      if (btn_rise[0]) seen = 1;
    end
    check("hold_rise_seen", 32'(seen), 32'h1);
    for (int k = 1; k < 200; k++) begin
      tick(1);
      check("hold_pulse", 32'(btn_hold[0]), 32'((k >= 100) && (((k - 100) % 20) == 0)));
    end
    btn_in = 4'b0000;
    seen = 0;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      tick(1);
      if (btn_fall[0]) seen = 1;
    end
    check("hold_fall_seen", 32'(seen), 32'h1);
    check("hold_none_on_fall", 32'(btn_hold[0]), 32'h0);
    h0 = hold_cnt[0];
    tick(40);
    check("hold_none_after_release", 32'(hold_cnt[0] - h0), 32'h0);
`endif

    // Randomized traffic with occasional resets; the monitor compares every cycle.
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < int'(CH); c++) begin
        if ($urandom_range(0, 19) == 0) btn_in[c] = ~btn_in[c];
      end
      reset = ($urandom_range(0, 599) == 0);
      tick(1);
    end
    reset = 1'b0;
    tick(2);

`ifndef MULTI_DEBOUNCER_HOLD_EN
    check("hold_tied_low", 32'(hold_cnt[0] + hold_cnt[1] + hold_cnt[2] + hold_cnt[3]), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
